data_memory: RTL and testbench

Data-memory responder for the single-cycle CPU's load/store port. It answers the CPU's address, write data, memRead/memWrite and memMode signals with readMemData in the same cycle. It provides a byte-addressable, little-endian RAM with sub-word stores and sign/zero-extended loads, plus a small memory-mapped I/O window with free-running counters and an output port. Misaligned accesses are suppressed and latched into a sticky fault record.

---
 rtl/data_memory_pkg.sv | 36 +++
 rtl/data_memory_lane_align.sv | 55 +++++
 rtl/data_memory.sv | 126 ++++++++++++
 tb/tb_data_memory.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: shared definitions for the data-memory responder.
// Holds access-mode encodings, the MMIO window map and lane helpers.
package data_memory_pkg;

    // memMode encodings as presented on the CPU load/store port.
    typedef enum logic [1:0] {
        MODE_WORD  = 2'b00,
        MODE_HALF  = 2'b01,
        MODE_BYTE  = 2'b10,
        MODE_BYTEU = 2'b11
    } mem_mode_e;

    // MMIO window: upper half-word selects it, low half-word is the offset.
    localparam logic [15:0] MMIO_BASE  = 16'hFFFF;
    localparam logic [15:0] MMIO_CYCLE = 16'h0000;
    localparam logic [15:0] MMIO_STORE = 16'h0004;
    localparam logic [15:0] MMIO_IOOUT = 16'h0008;

    // Byte lanes per 32-bit word.
    localparam int LANE_COUNT = 4;

    // Natural alignment check for an access of the given width.
    function automatic logic is_aligned(
        mem_mode_e  mode,
        logic [1:0] offset
    );
        logic ok;
        unique case (mode)
            MODE_WORD: ok = (offset == 2'b00);
            MODE_HALF: ok = ~offset[0];
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_lane_align.sv
// mem_lane_align: combinational lane steering for loads and stores.
// Ports: mode/offset select the access; store_data -> byte_en/store_word;
// load_word -> load_data (lane extracted and sign/zero extended).
module mem_lane_align
    import data_memory_pkg::*;
(
    input  logic [1:0]            mode,
    input  logic [1:0]            offset,
    input  logic [31:0]           store_data,
    input  logic [31:0]           load_word,
    output logic [LANE_COUNT-1:0] byte_en,
    output logic [31:0]           store_word,
    output logic [31:0]           load_data
);

    mem_mode_e   access_mode;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign access_mode = mem_mode_e'(mode);

    // Lane pair picked by offset[1]; single lane by offset[1:0].
    assign half_sel = offset[1] ? load_word[31:16] : load_word[15:0];
    assign byte_sel = load_word[{offset, 3'b000} +: 8];

    always_comb begin
        byte_en    = '0;
        store_word = store_data;
        load_data  = load_word;
        unique case (access_mode)
            MODE_WORD: begin
                byte_en    = 4'b1111;
                store_word = store_data;
                load_data  = load_word;
            end
            MODE_HALF: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                // Replicate so the enabled lanes see the low half.
                store_word = {2{store_data[15:0]}};
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            MODE_BYTE: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
                load_data  = {{24{byte_sel[7]}}, byte_sel};
            end
            MODE_BYTEU: begin
                byte_en    = 4'b0001 << offset;
                store_word = {4{store_data[7:0]}};
                load_data  = {24'h0, byte_sel};
            end
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: byte-addressable RAM plus MMIO counters/output port.
// Ports: clk/reset; dataAddress, writeMemData, memRead, memWrite, memMode
// from the CPU; readMemData (same-cycle load), ioOut/ioValid, fault/faultAddr.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int    ADDR_WIDTH = 10,
    parameter string INIT_FILE  = ""
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dataAddress,
    input  logic [31:0] writeMemData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  memMode,
    output logic [31:0] readMemData,
    output logic [31:0] ioOut,
    output logic        ioValid,
    output logic        fault,
    output logic [31:0] faultAddr
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [31:0] ram [WORDS];

    mem_mode_e             mode;
    logic                  is_mmio;
    logic                  aligned;
    logic                  misaligned;
    logic                  store_ok;
    logic                  ram_we;
    logic                  io_we;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [15:0]           mmio_off;
    logic [LANE_COUNT-1:0] byte_en;
    logic [31:0]           store_word;
    logic [31:0]           ram_word;
    logic [31:0]           mmio_word;
    logic [31:0]           load_word;
    logic [31:0]           load_data;
    logic [31:0]           cycle_count;
    logic [31:0]           store_count;

    assign mode     = mem_mode_e'(memMode);
    assign is_mmio  = (dataAddress[31:16] == MMIO_BASE);
    assign word_idx = dataAddress[ADDR_WIDTH+1:2];
    assign mmio_off = {dataAddress[15:2], 2'b00};
    assign aligned  = is_aligned(mode, dataAddress[1:0]);

    assign misaligned = (memRead | memWrite) & ~aligned;

    // Stores are dropped while reset is held or when misaligned.
    assign store_ok = memWrite & aligned & ~reset;
    assign ram_we   = store_ok & ~is_mmio;
    assign io_we    = store_ok & is_mmio
                    & (mmio_off == MMIO_IOOUT)
                    & (mode == MODE_WORD);

    assign ram_word = ram[word_idx];

    always_comb begin
        mmio_word = '0;
        case (mmio_off)
            MMIO_CYCLE: mmio_word = cycle_count;
            MMIO_STORE: mmio_word = store_count;
            MMIO_IOOUT: mmio_word = ioOut;
            default:    mmio_word = '0;
        endcase
    end

    assign load_word = is_mmio ? mmio_word : ram_word;

    mem_lane_align u_align (
        .mode       (memMode),
        .offset     (dataAddress[1:0]),
        .store_data (writeMemData),
        .load_word  (load_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data)
    );

    // Read path sees pre-edge state, so a combined read/write
    // returns the old value.
    assign readMemData = (memRead & aligned) ? load_data : '0;

    // RAM has no reset; only enabled lanes are updated.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < LANE_COUNT; i++) begin
                if (byte_en[i]) begin
                    ram[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            store_count <= '0;
            ioOut       <= '0;
            ioValid     <= 1'b0;
            fault       <= 1'b0;
            faultAddr   <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (ram_we) begin
                store_count <= store_count + 32'd1;
            end
            ioValid <= io_we;
            if (io_we) begin
                ioOut <= writeMemData;
            end
            // Only the first misaligned address is kept.
            if (misaligned && !fault) begin
                fault     <= 1'b1;
                faultAddr <= dataAddress;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed bench for data_memory.
// A byte-array reference model predicts loads, counters, ioOut and faults.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dataAddress;
    logic [31:0] writeMemData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memMode;
    logic [31:0] readMemData;
    logic [31:0] ioOut;
    logic        ioValid;
    logic        fault;
    logic [31:0] faultAddr;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [7:0]  m_ram [4096];
    logic [31:0] m_cycle, m_store, m_io, m_faddr;
    logic        m_iov, m_fault;

    data_memory #(.ADDR_WIDTH(10), .INIT_FILE("")) dut (
        .clk          (clk),
        .reset        (reset),
        .dataAddress  (dataAddress),
        .writeMemData (writeMemData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memMode      (memMode),
        .readMemData  (readMemData),
        .ioOut        (ioOut),
        .ioValid      (ioValid),
        .fault        (fault),
        .faultAddr    (faultAddr)
    );

    always #5 clk = ~clk;

    function automatic int width_of(logic [1:0] mode);
        return (mode == 2'd0) ? 4 : (mode == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a,
                                             logic [1:0] mode);
        int n;
        int lane;
        logic [31:0] w;
        logic [31:0] v;
        n = width_of(mode);
        v = 32'h0;
        w = 32'h0;
        if ((a % n) != 0) return 32'h0;
        if (a[31:16] == 16'hFFFF) begin
            case (a[15:0] & 16'hFFFC)
                16'h0000: w = m_cycle;
                16'h0004: w = m_store;
                16'h0008: w = m_io;
                default:  w = 32'h0;
            endcase
        end
        for (int k = 0; k < n; k++) begin
            if (a[31:16] == 16'hFFFF) begin
                lane = int'(a[1:0]) + k;
                v[8*k +: 8] = w[8*lane +: 8];
            end else begin
                v[8*k +: 8] = m_ram[(int'(a[11:0]) + k) % 4096];
            end
        end
        if (mode == 2'd1) v = {{16{v[15]}}, v[15:0]};
        else if (mode == 2'd2) v = {{24{v[7]}}, v[7:0]};
        return v;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [1:0] m,
                         input logic [31:0] a, input logic [31:0] d);
        memRead      = r;
        memWrite     = w;
        memMode      = m;
        dataAddress  = a;
        writeMemData = d;
    endtask

    // Advance one edge, updating the model with the effect of the
    // inputs currently presented.
    task automatic step();
        logic [31:0] a;
        int n;
        a = dataAddress;
        n = width_of(memMode);
        if (reset) begin
            m_cycle = 0; m_store = 0; m_io = 0;
            m_iov = 0; m_fault = 0; m_faddr = 0;
        end else begin
            m_cycle = m_cycle + 1;
            m_iov = 0;
            if ((memRead || memWrite) && (a % n) != 0) begin
                if (!m_fault) begin
                    m_fault = 1;
                    m_faddr = a;
                end
            end else if (memWrite) begin
                if (a[31:16] == 16'hFFFF) begin
                    if (a == 32'hFFFF0008 && n == 4) begin
                        m_io = writeMemData;
                        m_iov = 1;
                    end
                end else begin
                    for (int k = 0; k < n; k++)
                        m_ram[(int'(a[11:0]) + k) % 4096] =
                            writeMemData[8*k +: 8];
                    m_store = m_store + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        step();
        step();
        checks++;
        if (ioOut !== 32'h0 || ioValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_io got %h/%b exp 0/0", ioOut, ioValid);
        end
        checks++;
        if (fault !== 1'b0 || faultAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_fault got %b/%h exp 0/0", fault, faultAddr);
        end
        drive(0, 0, 2'd0, 32'hFFFF0000, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'h0) begin
            errors++;
            $display("FAIL idle_read got %h exp 0", readMemData);
        end
    endtask

    task automatic test_cycle_count();
        reset = 1'b0;
        drive(1, 0, 2'd0, 32'hFFFF0000, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'd0) begin
            errors++;
            $display("FAIL cycle_first got %0d exp 0", readMemData);
        end
        repeat (5) step();
        checks++;
        if (readMemData !== 32'd5) begin
            errors++;
            $display("FAIL cycle_five got %0d exp 5", readMemData);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 1024; i++) begin
            drive(0, 1, 2'd0, 32'(i * 4), $urandom);
            step();
        end
        drive(0, 0, 2'd0, 32'h0, 32'h0);
    endtask

    task automatic test_mixed_width();
        drive(0, 1, 2'd0, 32'h10, 32'h8899AABB);
        step();
        drive(0, 1, 2'd2, 32'h12, 32'h00000011);
        step();
        drive(0, 1, 2'd1, 32'h10, 32'h00002233);
        step();
        drive(1, 0, 2'd0, 32'h10, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'h88112233) begin
            errors++;
            $display("FAIL lw_mixed got %h exp 88112233", readMemData);
        end
        drive(1, 0, 2'd2, 32'h13, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'hFFFFFF88) begin
            errors++;
            $display("FAIL lb_sign got %h exp ffffff88", readMemData);
        end
        drive(1, 0, 2'd3, 32'h13, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'h00000088) begin
            errors++;
            $display("FAIL lbu_zero got %h exp 00000088", readMemData);
        end
        drive(1, 0, 2'd1, 32'h12, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'hFFFF8811) begin
            errors++;
            $display("FAIL lh_sign got %h exp ffff8811", readMemData);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] old;
        old = ref_load(32'h20, 2'd0);
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear got %b exp 0", fault);
        end
        drive(1, 1, 2'd0, 32'h21, 32'h00000001);
        #1;
        checks++;
        if (readMemData !== 32'h0) begin
            errors++;
            $display("FAIL misaligned_read got %h exp 0", readMemData);
        end
        step();
        checks++;
        if (fault !== 1'b1 || faultAddr !== 32'h21) begin
            errors++;
            $display("FAIL fault_set got %b/%h exp 1/21", fault, faultAddr);
        end
        drive(1, 0, 2'd0, 32'h20, 32'h0);
        #1;
        checks++;
        if (readMemData !== old) begin
            errors++;
            $display("FAIL misaligned_nowrite got %h exp %h", readMemData, old);
        end
        drive(1, 0, 2'd1, 32'h33, 32'h0);
        step();
        checks++;
        if (fault !== 1'b1 || faultAddr !== 32'h21) begin
            errors++;
            $display("FAIL fault_sticky got %b/%h exp 1/21", fault, faultAddr);
        end
    endtask

    task automatic test_store_count();
        reset = 1'b1;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        drive(0, 1, 2'd0, 32'h80, 32'h01020304);
        step();
        drive(0, 1, 2'd1, 32'h84, 32'h0000BEEF);
        step();
        drive(0, 1, 2'd3, 32'h86, 32'h0000007F);
        step();
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'h00000042);
        step();
        drive(1, 0, 2'd0, 32'hFFFF0004, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'd3) begin
            errors++;
            $display("FAIL store_count got %0d exp 3", readMemData);
        end
        drive(1, 0, 2'd0, 32'hFFFF0000, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'd4) begin
            errors++;
            $display("FAIL cycle_after_stores got %0d exp 4", readMemData);
        end
    endtask

    task automatic test_io_port();
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'hDEADBEEF);
        step();
        checks++;
        if (ioOut !== 32'hDEADBEEF || ioValid !== 1'b1) begin
            errors++;
            $display("FAIL io_write got %h/%b exp deadbeef/1", ioOut, ioValid);
        end
        drive(1, 0, 2'd0, 32'hFFFF0008, 32'h0);
        #1;
        checks++;
        if (readMemData !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL io_read got %h exp deadbeef", readMemData);
        end
        step();
        checks++;
        if (ioValid !== 1'b0) begin
            errors++;
            $display("FAIL io_pulse_end got %b exp 0", ioValid);
        end
        drive(0, 1, 2'd2, 32'hFFFF0008, 32'h00000055);
        step();
        checks++;
        if (ioOut !== 32'hDEADBEEF || ioValid !== 1'b0) begin
            errors++;
            $display("FAIL io_sb_ignored got %h/%b exp deadbeef/0", ioOut, ioValid);
        end
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'h11111111);
        step();
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'h22222222);
        step();
        checks++;
        if (ioOut !== 32'h22222222 || ioValid !== 1'b1) begin
            errors++;
            $display("FAIL io_b2b got %h/%b exp 22222222/1", ioOut, ioValid);
        end
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        step();
        checks++;
        if (ioValid !== 1'b0) begin
            errors++;
            $display("FAIL io_b2b_end got %b exp 0", ioValid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] old;
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'h12345678);
        step();
        reset = 1'b1;
        drive(0, 1, 2'd0, 32'hFFFF0008, 32'hCAFEF00D);
        step();
        checks++;
        if (ioOut !== 32'h0 || ioValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_io got %h/%b exp 0/0", ioOut, ioValid);
        end
        old = ref_load(32'h40, 2'd0);
        drive(0, 1, 2'd0, 32'h40, ~old);
        step();
        drive(1, 0, 2'd0, 32'h40, 32'h0);
        #1;
        checks++;
        if (readMemData !== old) begin
            errors++;
            $display("FAIL reset_nowrite got %h exp %h", readMemData, old);
        end
        reset = 1'b0;
        drive(0, 0, 2'd0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        v = $urandom;
        drive(0, 1, 2'd0, 32'h1000, v);
        step();
        drive(1, 0, 2'd0, 32'h0, 32'h0);
        #1;
        checks++;
        if (readMemData !== v) begin
            errors++;
            $display("FAIL wrap_alias got %h exp %h", readMemData, v);
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL wrap_nofault got %b exp 0", fault);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] exp;
        int kind;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 255));
            if (kind >= 6 && kind <= 7)
                a = {16'($urandom_range(0, 16'hFFFE)), 4'($urandom), a[11:0]};
            else if (kind >= 8)
                a = 32'hFFFF0000 | 32'($urandom_range(0, 15));
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 1) == 1),
                  2'($urandom), a, $urandom);
            #1;
            exp = memRead ? ref_load(a, memMode) : 32'h0;
            checks++;
            if (readMemData !== exp) begin
                errors++;
                $display("FAIL rnd_load a=%h m=%0d got %h exp %h",
                         a, memMode, readMemData, exp);
            end
            step();
            checks++;
            if (ioOut !== m_io || ioValid !== m_iov ||
                fault !== m_fault || faultAddr !== m_faddr) begin
                errors++;
                $display("FAIL rnd_state got %h/%b/%b/%h exp %h/%b/%b/%h",
                         ioOut, ioValid, fault, faultAddr,
                         m_io, m_iov, m_fault, m_faddr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cycle_count();
        test_fill();
        test_mixed_width();
        test_misalign();
        test_store_count();
        test_io_port();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
